// File: rtl/midi_poly.sv
// midi_poly: polyphonic MIDI note/program decoder with voice allocation and note stealing.
// Define MIDI_POLY_RUNNING_STATUS_EN to keep the stored status across messages (running status).
module midi_poly #(
  parameter int VOICES = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CE,
  input  logic [3:0]            CHANNEL,
  input  logic [7:0]            DATA,
  input  logic                  DV,
  output logic [7*VOICES-1:0]   NOTE_NUM,
  output logic [7*VOICES-1:0]   NOTE_VEL,
  output logic [VOICES-1:0]     GATE,
  output logic [6:0]            PROGRAM
);
  localparam int PW = VOICES > 1 ? $clog2(VOICES) : 1;
  typedef enum logic [2:0] {IDLE, RECV_NUM, RECV_VEL, HANDLE_NOTE, RECV_PROG, HANDLE_PROG, SKIP} state_t;
`ifdef MIDI_POLY_RUNNING_STATUS_EN
  localparam state_t NOTE_RET = RECV_NUM;
  localparam state_t PROG_RET = RECV_PROG;
`else
  localparam state_t NOTE_RET = IDLE;
  localparam state_t PROG_RET = IDLE;
`endif
  state_t state, status_next;
  logic is_on;
  logic [6:0] num_l, vel_l;
  logic [PW-1:0] steal, sel, match_idx, free_idx;
  logic match_any, free_any, note_on;
  // Descending scan leaves the lowest matching/free index in place.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (GATE[v] && NOTE_NUM[7*v +: 7] == num_l) begin
        match_any = 1'b1;
        match_idx = PW'(v);
      end
      if (!GATE[v]) begin
        free_any = 1'b1;
        free_idx = PW'(v);
      end
    end
    sel = match_any ? match_idx : free_any ? free_idx : steal;
  end
  assign note_on = is_on && vel_l != 7'd0;
  assign status_next = DATA[3:0] != CHANNEL ? SKIP :
                       (DATA[7:4] == 4'h8 || DATA[7:4] == 4'h9) ? RECV_NUM :
                       DATA[7:4] == 4'hC ? RECV_PROG : SKIP;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      is_on <= 1'b0;
      num_l <= '0;
      vel_l <= '0;
      steal <= '0;
      NOTE_NUM <= '0;
      NOTE_VEL <= '0;
      GATE <= '0;
      PROGRAM <= '0;
    end else if (CE) begin
      if (state == HANDLE_NOTE) begin
        state <= NOTE_RET;
        if (note_on) begin
          NOTE_NUM[7*sel +: 7] <= num_l;
          NOTE_VEL[7*sel +: 7] <= vel_l;
          GATE[sel] <= 1'b1;
          if (!match_any && !free_any)
            steal <= steal == PW'(VOICES - 1) ? '0 : steal + 1'b1;
        end else begin
          for (int v = 0; v < VOICES; v++)
            if (GATE[v] && NOTE_NUM[7*v +: 7] == num_l) begin
              GATE[v] <= 1'b0;
              NOTE_VEL[7*v +: 7] <= '0;
            end
        end
      end else if (state == HANDLE_PROG) begin
        state <= PROG_RET;
        PROGRAM <= num_l;
      end else if (DV && DATA < 8'hF8) begin
        if (DATA[7:4] == 4'hF) begin
          state <= SKIP;
          is_on <= 1'b0;
        end else if (DATA[7]) begin
          state <= status_next;
          is_on <= DATA[4];
        end else begin
          state <= state == RECV_NUM ? RECV_VEL : state == RECV_VEL ? HANDLE_NOTE :
                   state == RECV_PROG ? HANDLE_PROG : state;
          if (state == RECV_VEL) vel_l <= DATA[6:0];
          else num_l <= DATA[6:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_midi_poly.sv
// tb_midi_poly: directed byte-stream checks of midi_poly with VOICES=4, CHANNEL=0.
module tb_midi_poly;
  logic CLK = 1'b0;
  logic RST_N, CE, DV;
  logic [3:0] CHANNEL;
  logic [7:0] DATA;
  logic [27:0] NOTE_NUM, NOTE_VEL;
  logic [3:0] GATE;
  logic [6:0] PROGRAM;
  int n_chk = 0;
  int n_fail = 0;
  midi_poly #(.VOICES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CHANNEL(CHANNEL), .DATA(DATA), .DV(DV),
    .NOTE_NUM(NOTE_NUM), .NOTE_VEL(NOTE_VEL), .GATE(GATE), .PROGRAM(PROGRAM)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    DATA = b;
    DV = 1'b1;
    @(negedge CLK);
    DV = 1'b0;
  endtask
  task automatic msg3(input logic [7:0] s, input logic [7:0] n, input logic [7:0] v);
    send(s);
    send(n);
    send(v);
    @(negedge CLK);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_num"}, NOTE_NUM, 28'h0);
    chk({tag, "_vel"}, NOTE_VEL, 28'h0);
    chk({tag, "_gate"}, 28'(GATE), 28'h0);
    chk({tag, "_prog"}, 28'(PROGRAM), 28'h0);
  endtask
  initial begin
    RST_N = 1'b1;
    CE = 1'b1;
    DV = 1'b0;
    DATA = 8'h00;
    CHANNEL = 4'h0;
    #2 RST_N = 1'b0;
    #2 chk_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    send(8'h90);
    send(8'h3C);
    send(8'h64);
    chk("handle_not_yet", 28'(GATE), 28'h0);
    @(negedge CLK);
    chk("first_num", NOTE_NUM, 28'h000003C);
    chk("first_vel", NOTE_VEL, 28'h0000064);
    chk("first_gate", 28'(GATE), 28'h1);
    msg3(8'h90, 8'h40, 8'h50);
    msg3(8'h90, 8'h43, 8'h50);
    msg3(8'h90, 8'h48, 8'h50);
    chk("fill_gate", 28'(GATE), 28'hF);
    chk("fill_num", NOTE_NUM, {7'h48, 7'h43, 7'h40, 7'h3C});
    chk("fill_vel", NOTE_VEL, {7'h50, 7'h50, 7'h50, 7'h64});
    msg3(8'h80, 8'h40, 8'h00);
    chk("off80_gate", 28'(GATE), 28'hD);
    chk("off80_vel", NOTE_VEL, {7'h50, 7'h50, 7'h00, 7'h64});
    chk("off80_num_kept", NOTE_NUM, {7'h48, 7'h43, 7'h40, 7'h3C});
    msg3(8'h90, 8'h43, 8'h00);
    chk("off90v0_gate", 28'(GATE), 28'h9);
    chk("off90v0_vel", NOTE_VEL, {7'h50, 7'h00, 7'h00, 7'h64});
    msg3(8'h90, 8'h40, 8'h11);
    msg3(8'h90, 8'h43, 8'h22);
    chk("refill_gate", 28'(GATE), 28'hF);
    chk("refill_vel", NOTE_VEL, {7'h50, 7'h22, 7'h11, 7'h64});
    msg3(8'h90, 8'h4A, 8'h33);
    msg3(8'h90, 8'h4C, 8'h44);
    chk("steal_num", NOTE_NUM, {7'h48, 7'h43, 7'h4C, 7'h4A});
    chk("steal_vel", NOTE_VEL, {7'h50, 7'h22, 7'h44, 7'h33});
    msg3(8'h90, 8'h4E, 8'h55);
    chk("steal_ptr2_num", NOTE_NUM, {7'h48, 7'h4E, 7'h4C, 7'h4A});
    msg3(8'h90, 8'h48, 8'h7F);
    chk("retrig_num", NOTE_NUM, {7'h48, 7'h4E, 7'h4C, 7'h4A});
    chk("retrig_vel", NOTE_VEL, {7'h7F, 7'h55, 7'h44, 7'h33});
    msg3(8'h80, 8'h11, 8'h00);
    chk("unmatched_off_gate", 28'(GATE), 28'hF);
    chk("unmatched_off_vel", NOTE_VEL, {7'h7F, 7'h55, 7'h44, 7'h33});
    msg3(8'h91, 8'h3C, 8'h64);
    chk("other_ch_num", NOTE_NUM, {7'h48, 7'h4E, 7'h4C, 7'h4A});
    send(8'hC0);
    send(8'h05);
    @(negedge CLK);
    chk("prog5", 28'(PROGRAM), 28'h05);
    send(8'hC1);
    send(8'h07);
    @(negedge CLK);
    chk("prog_other_ch", 28'(PROGRAM), 28'h05);
    CE = 1'b0;
    msg3(8'h80, 8'h48, 8'h00);
    CE = 1'b1;
    @(negedge CLK);
    chk("ce_freeze_gate", 28'(GATE), 28'hF);
    msg3(8'h90, 8'h60, 8'h01);
    chk("steal_ptr3", NOTE_NUM, {7'h60, 7'h4E, 7'h4C, 7'h4A});
    msg3(8'h90, 8'h61, 8'h02);
    chk("steal_wrap", NOTE_NUM, {7'h60, 7'h4E, 7'h4C, 7'h61});
    send(8'hF0);
    send(8'h61);
    send(8'h00);
    @(negedge CLK);
    chk("sysex_gate", 28'(GATE), 28'hF);
    send(8'h90);
    send(8'h3C);
    @(negedge CLK);
    RST_N = 1'b0;
    #2 chk_zero("mid_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    send(8'h64);
    @(negedge CLK);
    @(negedge CLK);
    chk_zero("after_reset");
    send(8'h90);
    send(8'hF8);
    send(8'h3C);
    send(8'h64);
    @(negedge CLK);
    chk("rt_num", NOTE_NUM, 28'h000003C);
    chk("rt_vel", NOTE_VEL, 28'h0000064);
    chk("rt_gate", 28'(GATE), 28'h1);
    send(8'h3E);
    send(8'h50);
    @(negedge CLK);
    send(8'hC0);
    send(8'h09);
    @(negedge CLK);
    send(8'h0A);
    @(negedge CLK);
`ifdef MIDI_POLY_RUNNING_STATUS_EN
    chk("running_num", NOTE_NUM, {7'h00, 7'h00, 7'h3E, 7'h3C});
    chk("running_gate", 28'(GATE), 28'h3);
    chk("running_prog", 28'(PROGRAM), 28'h0A);
`else
    chk("no_running_num", NOTE_NUM, 28'h000003C);
    chk("no_running_gate", 28'(GATE), 28'h1);
    chk("no_running_prog", 28'(PROGRAM), 28'h09);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/midi_poly.md
MIDI_POLY -- requirements
Module: midi_poly

Interface
REQ-001 SHALL have parameter VOICES, default 4, range 1..16: number of independent voice slots.
REQ-002 SHALL have port CLK, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port RST_N, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port CE, input, 1: clock enable; state, outputs and the byte-accept condition are all frozen while low.
REQ-005 SHALL have port CHANNEL, input, 4: MIDI channel to respond to; sampled live.
REQ-006 SHALL have port DATA, input, 8: received MIDI byte.
REQ-007 SHALL have port DV, input, 1: DATA valid; a byte is accepted on an edge with CE=1 and DV=1.
REQ-008 SHALL have port NOTE_NUM, output, 7*VOICES: note number per voice; voice v occupies bits [7v+6:7v].
REQ-009 SHALL have port NOTE_VEL, output, 7*VOICES: velocity per voice, same packing as NOTE_NUM.
REQ-010 SHALL have port GATE, output, VOICES: bit v is 1 while voice v holds a sounding note.
REQ-011 SHALL have port PROGRAM, output, 7: last program-change value for CHANNEL.

Function
REQ-012 SHALL implement states IDLE, RECV_NUM, RECV_VEL, HANDLE_NOTE, RECV_PROG, HANDLE_PROG and SKIP.
REQ-013 Any accepted byte 0xF8-0xFF (realtime) SHALL be ignored without changing state or stored status.
REQ-014 Any accepted byte 0xF0-0xF7 SHALL clear stored status and move the FSM to SKIP.
REQ-015 Any other accepted status byte (DATA[7]=1), in any non-HANDLE state, SHALL abort the current message, be stored, and select the next state.
- 0x8n/0x9n with n=CHANNEL -> RECV_NUM.
- 0xCn with n=CHANNEL -> RECV_PROG.
- All other status bytes -> SKIP.
REQ-016 Data bytes SHALL be handled as follows.
- RECV_NUM: latch DATA[6:0], go to RECV_VEL.
- RECV_VEL: latch DATA[6:0], go to HANDLE_NOTE.
- RECV_PROG: latch DATA[6:0], go to HANDLE_PROG.
- IDLE, SKIP: discard.
REQ-017 HANDLE_* states SHALL last exactly one CE cycle; a byte accepted during a HANDLE_* cycle SHALL be dropped (upstream byte spacing is 320 us minimum).
REQ-018 Outputs SHALL update on the edge that leaves HANDLE_*, i.e. the second CE edge after the final data byte is accepted.
REQ-019 A note-on is status 0x9n with velocity >0; a note-off is status 0x8n, or 0x9n with velocity 0.
REQ-020 Note-on allocation SHALL apply the first matching rule below, then write NOTE_NUM and NOTE_VEL and set GATE for the chosen voice.
- A gated voice with the same note number -> retrigger that voice.
- Otherwise -> the lowest-index voice with GATE=0.
- Otherwise (all voices gated) -> the voice at the steal pointer; the pointer then increments modulo VOICES.
REQ-021 Note-off SHALL clear GATE and set NOTE_VEL to 0 for every gated voice whose note number matches; NOTE_NUM is retained; an unmatched note-off changes nothing.
REQ-022 HANDLE_PROG SHALL load PROGRAM from the latched byte.
REQ-023 With VOICES=1, the steal pointer SHALL stay at 0 and every new note SHALL replace voice 0.

Reset
REQ-024 While RST_N=0 the following SHALL hold immediately, independent of CLK and CE.
- Outputs: all NOTE_NUM, NOTE_VEL, GATE and PROGRAM bits = 0.
- Internal: steal pointer = 0, stored status cleared, FSM in IDLE.
REQ-025 Reset asserted mid-message SHALL discard the partial message; data bytes after release SHALL be ignored until a new status byte arrives.

Configuration
REQ-026 Macro MIDI_POLY_RUNNING_STATUS_EN defined: HANDLE_NOTE SHALL return to RECV_NUM and HANDLE_PROG to RECV_PROG, so data bytes without a new status byte reuse the stored status.
REQ-027 Macro MIDI_POLY_RUNNING_STATUS_EN undefined: both HANDLE_* states SHALL return to IDLE, so every message requires its own status byte.

Verification (VOICES=4, CHANNEL=0)
REQ-028 Bytes 90 3C 64 -> NOTE_NUM[0]=0x3C, NOTE_VEL[0]=0x64, GATE=0001, two CE edges after 0x64 is accepted.
REQ-029 Note-ons for 3C, 40, 43, 48, then 4A, then 4C -> 4A replaces voice 0 and 4C replaces voice 1; steal pointer ends at 2.
REQ-030 With voices holding 3C/40/43/48: 80 40 00 -> GATE=1101, NOTE_VEL[1]=0; then 90 43 00 -> GATE=1001.
REQ-031 Bytes 90 3C 64 3E 50 -> macro defined: voice 1 = 3E/50; macro undefined: voice 1 unchanged.
REQ-032 Bytes 91 3C 64 -> no change; C0 05 -> PROGRAM=5; 90 F8 3C 64 -> voice 0 = 3C/64.
REQ-033 RST_N pulsed low after 90 3C, then 64 -> all outputs 0 during reset and still 0 after the 64.
